// File: rtl/complex_pkg.sv
// ---------------------------------------------------------------------------
// complex_pkg
// Shared definitions for the complex-sample datapath blocks.
//   WL_DEFAULT : default MSB index of one real/imag component (S7.11 format)
//   CPLX_W     : component width at the default WL
//   CPLX_MAX   : most-positive component value,  2^WL - 1
//   CPLX_MIN   : most-negative component value, -2^WL
// ---------------------------------------------------------------------------
package complex_pkg;

  localparam int WL_DEFAULT = 18;
  localparam int CPLX_W     = WL_DEFAULT + 1;

  localparam logic signed [CPLX_W-1:0] CPLX_MAX = {1'b0, {WL_DEFAULT{1'b1}}};
  localparam logic signed [CPLX_W-1:0] CPLX_MIN = {1'b1, {WL_DEFAULT{1'b0}}};

endpackage : complex_pkg

// File: rtl/complex_mux_nto1_reg_if.sv
// ---------------------------------------------------------------------------
// complex_mux_nto1_reg_if
// Bus bundle for complex_mux_nto1_reg: input channels with valid/ready,
// select controls, and the registered output beat with valid/ready.
//   master modport : upstream/downstream environment driving the selector
//   slave modport  : the selector itself
// Optional signal conj exists only when COMPLEX_MUX_CONJ_EN is defined.
// ---------------------------------------------------------------------------
interface complex_mux_nto1_reg_if
  import complex_pkg::*;
#(
  parameter int WL = WL_DEFAULT,
  parameter int N  = 4,
  parameter int SW = $clog2(N)
);

  logic [N*(WL+1)-1:0] in_real;
  logic [N*(WL+1)-1:0] in_imag;
  logic                in_valid;
  logic                in_ready;
  logic [SW-1:0]       sel;
  logic                mode;
`ifdef COMPLEX_MUX_CONJ_EN
  logic                conj;
`endif
  logic signed [WL:0]  out_real;
  logic signed [WL:0]  out_imag;
  logic [SW-1:0]       out_ch;
  logic                out_last;
  logic                out_valid;
  logic                out_ready;

  modport master (
    output in_real, in_imag, in_valid, sel, mode,
`ifdef COMPLEX_MUX_CONJ_EN
    output conj,
`endif
    output out_ready,
    input  in_ready, out_real, out_imag, out_ch, out_last, out_valid
  );

  modport slave (
    input  in_real, in_imag, in_valid, sel, mode,
`ifdef COMPLEX_MUX_CONJ_EN
    input  conj,
`endif
    input  out_ready,
    output in_ready, out_real, out_imag, out_ch, out_last, out_valid
  );

endinterface : complex_mux_nto1_reg_if

// File: rtl/complex_neg_sat.sv
// ---------------------------------------------------------------------------
// complex_neg_sat
// Combinational saturating negate of one signed component.
//   din  : signed component, WL+1 bits
//   dout : -din, with -(-2^WL) saturated to 2^WL - 1
// ---------------------------------------------------------------------------
module complex_neg_sat
  import complex_pkg::*;
#(
  parameter int WL = WL_DEFAULT
) (
  input  logic signed [WL:0] din,
  output logic signed [WL:0] dout
);

  localparam logic signed [WL:0] MAX_VAL = {1'b0, {WL{1'b1}}};
  localparam logic signed [WL:0] MIN_VAL = {1'b1, {WL{1'b0}}};

  // The two's-complement negation of the most-negative value wraps back to
  // itself, so that one code is clamped explicitly.
  always_comb begin
    if (din == MIN_VAL) dout = MAX_VAL;
    else                dout = -din;
  end

endmodule : complex_neg_sat

// File: rtl/complex_mux_nto1_reg.sv
// ---------------------------------------------------------------------------
// complex_mux_nto1_reg
// N-way complex-sample selector with one registered output stage and a
// valid/ready handshake. The channel is either taken from bus.sel (mode=0)
// or from an internal sequencer that steps 0..N-1 on each accepted beat
// (mode=1), e.g. to serialise butterfly outputs.
//
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset
//   bus  : complex_mux_nto1_reg_if.slave
//          in_real/in_imag (packed channels, ch k at [k*(WL+1) +: WL+1]),
//          in_valid/in_ready, sel, mode, out_real/out_imag, out_ch,
//          out_last, out_valid/out_ready
//
// Configuration macro: COMPLEX_MUX_CONJ_EN
//   defined   : bus.conj selects a saturating negate of the imag part
//   undefined : imag passes through bit-exact
// ---------------------------------------------------------------------------
module complex_mux_nto1_reg
  import complex_pkg::*;
#(
  parameter int WL = WL_DEFAULT,
  parameter int N  = 4,
  parameter int SW = $clog2(N)
) (
  input logic                    clk,
  input logic                    rst,
  complex_mux_nto1_reg_if.slave  bus
);

  localparam int CW = WL + 1;

  logic [SW-1:0]      seq_cnt;
  logic [SW-1:0]      ch_idx;
  logic signed [WL:0] sel_real;
  logic signed [WL:0] sel_imag;
  logic signed [WL:0] imag_d;
  logic               last_d;
  logic               accept;

  logic signed [WL:0] out_real_q;
  logic signed [WL:0] out_imag_q;
  logic [SW-1:0]      out_ch_q;
  logic               out_last_q;
  logic               out_valid_q;

  // The stage can take a new beat whenever it is empty or being drained.
  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  assign ch_idx = bus.mode ? seq_cnt : bus.sel;
  assign last_d = bus.mode && (seq_cnt == SW'(N - 1));

  // NOTE: every signal driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  // An index with no matching channel (sel >= N) leaves the zero default.
  always_comb begin
    sel_real = '0;
    sel_imag = '0;
    for (int k = 0; k < N; k++) begin
      if (ch_idx == SW'(k)) begin
        sel_real = bus.in_real[k*CW +: CW];
        sel_imag = bus.in_imag[k*CW +: CW];
      end
    end
  end

`ifdef COMPLEX_MUX_CONJ_EN
  logic signed [WL:0] neg_imag;

  complex_neg_sat #(.WL(WL)) u_neg_sat (
    .din  (sel_imag),
    .dout (neg_imag)
  );

  assign imag_d = bus.conj ? neg_imag : sel_imag;
`else
  assign imag_d = sel_imag;
`endif

  // Sequencer is pinned to 0 outside auto mode so each auto run starts at
  // channel 0.
  // NOTE: state registers use non-blocking assignments so every always_ff
  // samples pre-edge values regardless of evaluation order.
  always_ff @(posedge clk) begin
    if (rst || !bus.mode) begin
      seq_cnt <= '0;
    end else if (accept) begin
      seq_cnt <= (seq_cnt == SW'(N - 1)) ? '0 : seq_cnt + SW'(1);
    end
  end

  // NOTE: the data registers are reset along with valid so the outputs read
  // as zero after reset rather than carrying stale samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_real_q  <= '0;
      out_imag_q  <= '0;
      out_ch_q    <= '0;
      out_last_q  <= 1'b0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      out_real_q  <= sel_real;
      out_imag_q  <= imag_d;
      out_ch_q    <= ch_idx;
      out_last_q  <= last_d;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_real  = out_real_q;
  assign bus.out_imag  = out_imag_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_last  = out_last_q;

endmodule : complex_mux_nto1_reg

// File: doc/complex_mux_nto1_reg.md
# complex_mux_nto1_reg

Parametrised N-way complex-sample selector with a registered output stage and a valid/ready handshake. It is the successor to the combinational 2-to-1 complex multiplexers in the FFT datapath. The block can either follow an external select or step through the input channels automatically, for example to serialise butterfly outputs. Samples use the datapath's signed fixed-point format (S7.11 at default width).

## Interface
Parameters:
- WL, 18, MSB index of each real/imag component; component width is WL+1 (S7.11 at default)
- N, 4, number of complex input channels (N ≥ 2)
- SW, $clog2(N), select/channel-index width

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_real  in  N*(WL+1)  packed signed real parts; channel k occupies bits [k*(WL+1) +: WL+1]
- in_imag  in  N*(WL+1)  packed signed imag parts, same packing
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- sel  in  SW  channel select, used in direct mode
- mode  in  1  0 = direct (use sel), 1 = auto sequencer
- out_real  out  WL+1  selected real part, registered
- out_imag  out  WL+1  selected imag part, registered
- out_ch  out  SW  channel index of the current output beat
- out_last  out  1  in auto mode, high on the beat carrying channel N-1
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts the output beat

## Operation
- Single output register stage.
- in_ready = !out_valid || out_ready.
- An input beat is accepted when in_valid && in_ready. On acceptance, the register loads the selected channel's real/imag, the channel index, and out_last.
- out_valid is set on acceptance. It is cleared when out_valid && out_ready and no new beat is accepted in the same cycle.
- Channel index:
  - Direct mode: sel.
  - Auto mode: internal counter seq_cnt.
- seq_cnt behaviour:
  - Increments on each accepted beat in auto mode.
  - Wraps from N-1 to 0.
  - Held at 0 whenever mode=0, so every entry into auto mode starts at channel 0.
- out_last = mode && (seq_cnt == N-1), captured with the beat. It is always 0 in direct mode.
- Out-of-range select (sel ≥ N, possible only when N is not a power of two): the beat is accepted, out_real = out_imag = 0, and out_ch = sel.
- Arithmetic: pure selection, no width change. Bits pass through unchanged, except when the conjugate feature below is active.
- mode or sel changing while out_valid && !out_ready: the held output is unaffected. The new value applies to the next accepted beat.

## Timing
- Latency: 1 cycle from acceptance to out_valid.
- Throughput: 1 beat/cycle when out_ready is held high.
- Output hold: with out_valid=1 and out_ready=0, all outputs are stable and in_ready=0.
- Reset (any cycle, including mid-stream), taking effect at the next clock edge:
  - out_valid=0, out_real=0, out_imag=0, out_ch=0, out_last=0, seq_cnt=0.
  - in_ready is therefore 1 in the first post-reset cycle.
  - A beat presented during rst is dropped.
- Simultaneous output consume and input accept: the register reloads and out_valid stays 1. There is no bubble.

## Configuration
- COMPLEX_MUX_CONJ_EN defined:
  - Adds input port conj (1 bit), sampled with each accepted beat.
  - When conj=1, out_imag = -imag, saturated. The most-negative value −2^WL maps to 2^WL−1. out_real is unchanged.
- COMPLEX_MUX_CONJ_EN undefined:
  - The conj port is absent.
  - out_imag is always the selected imag part, bit-exact.

## Structure
- Shared package complex_pkg:
  - WL default.
  - Component-width localparam CPLX_W = WL+1.
  - Saturation constants CPLX_MAX = 2^WL−1 and CPLX_MIN = −2^WL.
- Optional sub-module complex_neg_sat: combinational saturating negate of one component. Instantiated only under COMPLEX_MUX_CONJ_EN.
- The channel selector and sequencer stay in the top module.

## Test plan
Use N=4, WL=18, hex values 19-bit.
- Reset: assert rst for 2 cycles with in_valid=1 -> out_valid=0, out_real=out_imag=0, out_ch=0; in_ready=1 after release.
- Direct select: mode=0, sel=2, ch2=(0x00800, 0x7F800), in_valid=1, out_ready=1 -> next cycle out_valid=1, out_real=0x00800, out_imag=0x7F800, out_ch=2, out_last=0.
- Backpressure: out_valid=1, out_ready=0 for 3 cycles while sel and inputs change -> in_ready=0, outputs held. Release out_ready -> the new beat appears one cycle later, with no loss or duplication.
- Auto sequence: mode=1, 5 consecutive accepted beats -> out_ch 0,1,2,3,0; out_last high only on the 4th beat.
- Conjugate (macro defined): conj=1 with imag 0x40000 -> out_imag 0x3FFFF; with imag 0x00800 -> 0x7F800; real unchanged.
- Mid-stream reset: mode=1 after 2 beats (seq_cnt=2), out_valid=1, assert rst 1 cycle -> out_valid=0. The next accepted beat carries out_ch=0.
